// File: rtl/s_core_loader.sv
// Byte-stream boot loader for s_core: parses INST/REG/GO/HALT frames and
// drives the core's setup-side instruction-memory, register-file and start-PC ports.
module s_core_loader (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_rx_ready,
  output logic        o_setup,
  output logic [31:0] o_inst_mem_addr,
  output logic [31:0] o_inst_mem_data,
  output logic        o_inst_we,
  output logic [4:0]  o_load_reg_addr,
  output logic [31:0] o_load_reg_data,
  output logic        o_reg_we,
  output logic [31:0] o_pc_instr_start_addr,
  output logic [15:0] o_frame_count,
  output logic        o_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_INST_A, S_INST_D, S_REG_A, S_REG_D, S_GO_A, S_RUN
  } state_t;

  state_t      r_state;
  logic [1:0]  r_cnt;
  logic [31:0] r_shift;
  logic [31:0] r_addr_hold;
  logic [4:0]  r_idx_hold;
  logic        r_rx_ready;
  logic        r_setup;
  logic [31:0] r_inst_addr;
  logic [31:0] r_inst_data;
  logic        r_inst_we;
  logic [4:0]  r_reg_addr;
  logic [31:0] r_reg_data;
  logic        r_reg_we;
  logic [31:0] r_pc;
  logic [15:0] r_frame_count;
  logic        r_err;

  logic        w_accept;
  logic        w_last;
  logic [31:0] w_word;

  assign w_accept = i_rx_valid & r_rx_ready;
  assign w_last   = (r_cnt == 2'd3);
  // Bytes arrive LSB first, so each new byte enters at the top and the word
  // is complete once the fourth byte has shifted in.
  assign w_word   = {i_rx_data, r_shift[31:8]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_shift       <= '0;
      r_addr_hold   <= '0;
      r_idx_hold    <= '0;
      r_rx_ready    <= 1'b0;
      r_setup       <= 1'b1;
      r_inst_addr   <= '0;
      r_inst_data   <= '0;
      r_inst_we     <= 1'b0;
      r_reg_addr    <= '0;
      r_reg_data    <= '0;
      r_reg_we      <= 1'b0;
      r_pc          <= '0;
      r_frame_count <= '0;
      r_err         <= 1'b0;
    end else begin
      r_rx_ready <= 1'b1;
      r_inst_we  <= 1'b0;
      r_reg_we   <= 1'b0;
      if (w_accept) begin
        r_shift <= w_word;
        r_cnt   <= r_cnt + 2'd1;
        case (r_state)
          S_IDLE: begin
            r_cnt <= '0;
            case (i_rx_data)
              8'h00, 8'h04: r_state <= S_IDLE;
              8'h01:        r_state <= S_INST_A;
              8'h02:        r_state <= S_REG_A;
              8'h03:        r_state <= S_GO_A;
              default:      r_err   <= 1'b1;
            endcase
          end
          S_INST_A: if (w_last) begin
            r_addr_hold <= w_word;
            r_cnt       <= '0;
            r_state     <= S_INST_D;
          end
          S_INST_D: if (w_last) begin
            r_inst_addr   <= r_addr_hold;
            r_inst_data   <= w_word;
            r_inst_we     <= 1'b1;
            r_frame_count <= r_frame_count + 16'd1;
            r_cnt         <= '0;
            r_state       <= S_IDLE;
          end
          S_REG_A: begin
            r_idx_hold <= i_rx_data[4:0];
            r_cnt      <= '0;
            r_state    <= S_REG_D;
          end
          S_REG_D: if (w_last) begin
            r_reg_addr    <= r_idx_hold;
            r_reg_data    <= w_word;
            r_reg_we      <= 1'b1;
            r_frame_count <= r_frame_count + 16'd1;
            r_cnt         <= '0;
            r_state       <= S_IDLE;
          end
          S_GO_A: if (w_last) begin
            r_pc          <= w_word;
            r_setup       <= 1'b0;
            r_frame_count <= r_frame_count + 16'd1;
            r_cnt         <= '0;
            r_state       <= S_RUN;
          end
          S_RUN: begin
            r_cnt <= '0;
            if (i_rx_data == 8'h04) begin
              r_setup       <= 1'b1;
              r_frame_count <= r_frame_count + 16'd1;
              r_state       <= S_IDLE;
            end
          end
          default: begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign o_rx_ready            = r_rx_ready;
  assign o_setup               = r_setup;
  assign o_inst_mem_addr       = r_inst_addr;
  assign o_inst_mem_data       = r_inst_data;
  assign o_inst_we             = r_inst_we;
  assign o_load_reg_addr       = r_reg_addr;
  assign o_load_reg_data       = r_reg_data;
  assign o_reg_we              = r_reg_we;
  assign o_pc_instr_start_addr = r_pc;
  assign o_frame_count         = r_frame_count;
  assign o_err                 = r_err;

endmodule

// File: tb/tb_s_core_loader.sv
// Directed bench for s_core_loader: frames are driven byte by byte and every
// expected value below is hand-computed from the frame contents.
module tb_s_core_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  i_rx_data = '0;
  logic        i_rx_valid = 1'b0;
  logic        o_rx_ready, o_setup, o_inst_we, o_reg_we, o_err;
  logic [31:0] o_inst_mem_addr, o_inst_mem_data, o_load_reg_data, o_pc_instr_start_addr;
  logic [4:0]  o_load_reg_addr;
  logic [15:0] o_frame_count;

  int n_cmp = 0;
  int n_err = 0;

  s_core_loader dut (
    .clk                  (clk),
    .rst                  (rst),
    .i_rx_data            (i_rx_data),
    .i_rx_valid           (i_rx_valid),
    .o_rx_ready           (o_rx_ready),
    .o_setup              (o_setup),
    .o_inst_mem_addr      (o_inst_mem_addr),
    .o_inst_mem_data      (o_inst_mem_data),
    .o_inst_we            (o_inst_we),
    .o_load_reg_addr      (o_load_reg_addr),
    .o_load_reg_data      (o_load_reg_data),
    .o_reg_we             (o_reg_we),
    .o_pc_instr_start_addr(o_pc_instr_start_addr),
    .o_frame_count        (o_frame_count),
    .o_err                (o_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one byte across a single rising edge; returns 1ns after that edge.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    @(posedge clk);
    #1;
    i_rx_valid = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] stall_bytes [9];

    #1 rst = 1'b1;
    #2;
    chk("rst_setup", {31'd0, o_setup}, 32'd1);
    chk("rst_ready", {31'd0, o_rx_ready}, 32'd0);
    chk("rst_frames", {16'd0, o_frame_count}, 32'd0);
    chk("rst_err", {31'd0, o_err}, 32'd0);
    chk("rst_iaddr", o_inst_mem_addr, 32'd0);
    chk("rst_pc", o_pc_instr_start_addr, 32'd0);
    #9 rst = 1'b0;
    idle(1);
    chk("ready_after_rst", {31'd0, o_rx_ready}, 32'd1);

    // INST frame
    send(8'h01); send(8'h04); send(8'h00); send(8'h00); send(8'h00);
    send(8'h13); send(8'h74); send(8'h12);
    chk("inst_pre_addr", o_inst_mem_addr, 32'd0);
    chk("inst_pre_we", {31'd0, o_inst_we}, 32'd0);
    send(8'h00);
    chk("inst_addr", o_inst_mem_addr, 32'h0000_0004);
    chk("inst_data", o_inst_mem_data, 32'h0012_7413);
    chk("inst_we", {31'd0, o_inst_we}, 32'd1);
    chk("inst_frames", {16'd0, o_frame_count}, 32'd1);
    chk("inst_setup", {31'd0, o_setup}, 32'd1);
    idle(1);
    chk("inst_we_once", {31'd0, o_inst_we}, 32'd0);

    // REG frame, back to back, index byte upper bits ignored
    send(8'h02); send(8'hE4); send(8'h01); send(8'h11); send(8'h00); send(8'h00);
    chk("reg_addr", {27'd0, o_load_reg_addr}, 32'd4);
    chk("reg_data", o_load_reg_data, 32'h0000_1101);
    chk("reg_we", {31'd0, o_reg_we}, 32'd1);
    chk("reg_inst_we", {31'd0, o_inst_we}, 32'd0);
    chk("reg_inst_addr", o_inst_mem_addr, 32'h0000_0004);
    chk("reg_inst_data", o_inst_mem_data, 32'h0012_7413);
    chk("reg_frames", {16'd0, o_frame_count}, 32'd2);
    idle(1);
    chk("reg_we_once", {31'd0, o_reg_we}, 32'd0);

    // GO then junk then HALT
    send(8'h03); send(8'h04); send(8'h00); send(8'h00);
    chk("go_pre_setup", {31'd0, o_setup}, 32'd1);
    chk("go_pre_pc", o_pc_instr_start_addr, 32'd0);
    send(8'h00);
    chk("go_pc", o_pc_instr_start_addr, 32'h0000_0004);
    chk("go_setup", {31'd0, o_setup}, 32'd0);
    chk("go_frames", {16'd0, o_frame_count}, 32'd3);
    send(8'h55);
    chk("run_junk_setup", {31'd0, o_setup}, 32'd0);
    chk("run_junk_frames", {16'd0, o_frame_count}, 32'd3);
    chk("run_junk_err", {31'd0, o_err}, 32'd0);
    send(8'h04);
    chk("halt_setup", {31'd0, o_setup}, 32'd1);
    chk("halt_frames", {16'd0, o_frame_count}, 32'd4);

    // No-ops in IDLE, then a bad opcode
    send(8'h04); send(8'h00);
    chk("noop_frames", {16'd0, o_frame_count}, 32'd4);
    chk("noop_err", {31'd0, o_err}, 32'd0);
    send(8'h7F);
    chk("bad_err", {31'd0, o_err}, 32'd1);
    chk("bad_frames", {16'd0, o_frame_count}, 32'd4);

    // INST frame with 3-cycle gaps between bytes
    stall_bytes = '{8'h01, 8'h10, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    for (int i = 0; i < 8; i++) begin
      send(stall_bytes[i]);
      idle(3);
    end
    chk("stall_hold_addr", o_inst_mem_addr, 32'h0000_0004);
    chk("stall_hold_data", o_inst_mem_data, 32'h0012_7413);
    chk("stall_hold_we", {31'd0, o_inst_we}, 32'd0);
    send(stall_bytes[8]);
    chk("stall_addr", o_inst_mem_addr, 32'h0000_0010);
    chk("stall_data", o_inst_mem_data, 32'hDEAD_BEEF);
    chk("stall_we", {31'd0, o_inst_we}, 32'd1);
    chk("stall_frames", {16'd0, o_frame_count}, 32'd5);
    chk("err_sticky", {31'd0, o_err}, 32'd1);

    // Asynchronous reset in the middle of a frame
    send(8'h01); send(8'hAA); send(8'hBB);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_addr", o_inst_mem_addr, 32'd0);
    chk("mid_rst_data", o_inst_mem_data, 32'd0);
    chk("mid_rst_regdata", o_load_reg_data, 32'd0);
    chk("mid_rst_pc", o_pc_instr_start_addr, 32'd0);
    chk("mid_rst_frames", {16'd0, o_frame_count}, 32'd0);
    chk("mid_rst_err", {31'd0, o_err}, 32'd0);
    chk("mid_rst_ready", {31'd0, o_rx_ready}, 32'd0);
    #1 rst = 1'b0;
    idle(1);
    send(8'h01); send(8'h20); send(8'h00); send(8'h00); send(8'h00);
    send(8'h78); send(8'h56); send(8'h34); send(8'h12);
    chk("post_rst_addr", o_inst_mem_addr, 32'h0000_0020);
    chk("post_rst_data", o_inst_mem_data, 32'h1234_5678);
    chk("post_rst_we", {31'd0, o_inst_we}, 32'd1);
    chk("post_rst_frames", {16'd0, o_frame_count}, 32'd1);

    // Frame counter wrap from a forced preload
    force dut.r_frame_count = 16'hFFFF;
    idle(1);
    release dut.r_frame_count;
    idle(1);
    send(8'h02); send(8'hFF); send(8'h01); send(8'h00); send(8'h00); send(8'h00);
    chk("wrap_frames", {16'd0, o_frame_count}, 32'd0);
    chk("wrap_reg_addr", {27'd0, o_load_reg_addr}, 32'h1F);
    chk("wrap_reg_data", o_load_reg_data, 32'h0000_0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish before 200000ns");
    $fatal(1);
  end

endmodule

// File: doc/s_core_loader.md
# s_core_loader

Hardware boot loader that drives the `s_core` setup interface from a byte stream: it parses framed commands and writes instruction-memory words and register-file values. It then loads the start PC and releases the core from setup. It sits between a byte source (UART receiver, JTAG FIFO, or testbench) and the setup-side ports of `s_core`, and replaces hand-driven setup stimulus.

## Interface
- No parameters. Widths are fixed to the `s_core` setup interface.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `i_rx_data` in 8: incoming byte.
- `i_rx_valid` in 1: byte valid.
- `o_rx_ready` out 1: loader can accept a byte.
- `o_setup` out 1: drives `s_core` setup; 1 = core held in load mode.
- `o_inst_mem_addr` out 32: instruction-memory write address.
- `o_inst_mem_data` out 32: instruction-memory write data.
- `o_inst_we` out 1: one-cycle strobe when a new inst address/data pair is committed.
- `o_load_reg_addr` out 5: register-file write index.
- `o_load_reg_data` out 32: register-file write data.
- `o_reg_we` out 1: one-cycle strobe when a new register pair is committed.
- `o_pc_instr_start_addr` out 32: start PC for the core.
- `o_frame_count` out 16: number of completed frames; wraps.
- `o_err` out 1: sticky flag for an unknown opcode.

## Operation
- A byte is accepted on a rising edge where `i_rx_valid & o_rx_ready`. `o_rx_ready` is 1 in every state except during reset.
- All multi-byte fields are sent LSB first.
- Frame formats:
  - `0x01` INST: 4 address bytes, then 4 data bytes.
  - `0x02` REG: 1 index byte (bits [4:0] used, [7:5] ignored), then 4 data bytes.
  - `0x03` GO: 4 start-PC bytes.
  - `0x04` HALT: valid only in RUN.
- State machine:
  - IDLE: `0x01`→INST_A, `0x02`→REG_A, `0x03`→GO_A. `0x00` and `0x04` are no-ops. Any other byte sets `o_err` and stays in IDLE.
  - INST_A: after 4 bytes →INST_D.
  - INST_D: after 4 bytes → commit, →IDLE.
  - REG_A: after 1 byte →REG_D.
  - REG_D: after 4 bytes → commit, →IDLE.
  - GO_A: after 4 bytes → commit, →RUN.
  - RUN: `0x04` → `o_setup`=1, →IDLE. All other bytes are accepted and discarded.
- Field assembly:
  - A 2-bit byte counter and a 32-bit shift/assembly register are used; the counter clears on every state change.
  - Address and data bytes assemble into internal holding registers.
  - Visible outputs update only at commit, so the core never sees a half-built word.
- Commit actions:
  - INST: load `o_inst_mem_addr` and `o_inst_mem_data`; pulse `o_inst_we`.
  - REG: load `o_load_reg_addr` and `o_load_reg_data`; pulse `o_reg_we`.
  - GO: load `o_pc_instr_start_addr`; clear `o_setup`.
  - Every commit increments `o_frame_count` (0xFFFF→0x0000). A HALT also counts as a frame.
- Because `s_core` writes continuously while setup=1, the held addr/data pairs are rewritten every cycle. This is idempotent by design.
- REG frames with index 0 are forwarded unchanged; the core ignores writes to x0.
- Reset (asynchronous) behaviour:
  - State = IDLE, `o_setup`=1, `o_rx_ready`=0.
  - All address, data and PC outputs = 0; strobes = 0; `o_frame_count`=0; `o_err`=0.
  - `o_rx_ready` rises on the first edge after `rst` deasserts.
  - Reset mid-frame discards the partial frame.

## Timing
- Commit occurs on the same edge that accepts the final byte of a frame. The new output values and the strobe are visible for the following cycle.
- `o_setup` falls on the edge accepting the 4th GO byte. `o_pc_instr_start_addr` is valid from that same edge, so both change together.
- HALT: `o_setup` rises on the edge accepting `0x04`.
- Throughput is one byte per cycle with no bubbles:
  - INST frame: 9 cycles.
  - REG frame: 6 cycles.
  - GO frame: 5 cycles.
- Back-to-back frames need no gap; a new opcode may be accepted on the cycle after a commit.
- When `i_rx_valid`=0 mid-frame, the state and counter hold indefinitely. There is no timeout.

## Test plan
- INST frame: send `01 04 00 00 00 13 74 12 00` → one cycle after the last byte, `o_inst_mem_addr`=0x00000004, `o_inst_mem_data`=0x00127413, `o_inst_we` high for exactly 1 cycle, `o_frame_count`=1, `o_setup`=1.
- REG frame: send `02 E4 01 11 00 00` → `o_load_reg_addr`=5'b00100, `o_load_reg_data`=0x00001101, `o_reg_we` pulses once, and the inst outputs are unchanged.
- GO then HALT: send `03 04 00 00 00` → `o_pc_instr_start_addr`=0x00000004 and `o_setup`=0 on the same cycle. Then send `55 04` → `0x55` is ignored; `o_setup` returns to 1 after `04`; `o_frame_count` += 2.
- Bad opcode and stalls: send `7F` → `o_err`=1 (sticky), state stays IDLE. Then send an INST frame with `i_rx_valid` gaps of 3 cycles between bytes → correct commit, and the outputs stay unchanged until the last byte.
- Reset mid-frame: send `01 AA BB`, then pulse `rst` asynchronously between edges → all outputs return to reset values immediately. A following complete INST frame commits correctly with no leftover bytes.
- Counter wrap: preload via 65535 `00`-free REG frames (or force) → `o_frame_count` 0xFFFF→0x0000 on the next commit.
